// File: rtl/rgbw_pkg.sv
// ---------------------------------------------------------------------------
// rgbw_pkg
// Shared definitions for the RGBW output path (frame scheduler and serializer).
//   - FIFO word layout: [31] valid, [30] stream_reset, [23:0] {G,R,B}, rest 0
//   - STREAM_RST_WORD: the word that tells the serializer to emit a latch gap
//   - frame_state_t: scheduler FSM encoding
//   - pixel_word(): packs a 24-bit G/R/B pixel into a valid FIFO word
// ---------------------------------------------------------------------------
package rgbw_pkg;

  localparam int BNUM_VALID        = 31;
  localparam int BNUM_STREAM_RESET = 30;

  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam logic [31:0] STREAM_RST_WORD = 32'hC000_0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_PUSH     = 3'd3,
    ST_RST_WORD = 3'd4,
    ST_DONE     = 3'd5
  } frame_state_t;

  function automatic logic [31:0] pixel_word(input logic [23:0] grb);
    logic [31:0] w;
    w                = '0;
    w[BNUM_VALID]    = 1'b1;
    w[G_MSB:G_LSB]   = grb[G_MSB:G_LSB];
    w[R_MSB:R_LSB]   = grb[R_MSB:R_LSB];
    w[B_MSB:B_LSB]   = grb[B_MSB:B_LSB];
    return w;
  endfunction

endpackage

// File: rtl/rgbw_frame_timer.sv
// ---------------------------------------------------------------------------
// rgbw_frame_timer
// Refresh-period down-counter. Counts FRAME_PERIOD-1 .. 0 while enabled and
// flags a tick on the terminal count, reloading in the same clock, so ticks
// are exactly FRAME_PERIOD clocks apart. Disabling freezes and reloads the
// counter: a re-enable always waits one full period before the first tick.
// Ports:
//   clk       in  system clock
//   rst_n     in  async active-low reset (already release-synchronized)
//   i_enable  in  1 = count, 0 = hold at reload value
//   o_tick    out 1-clk refresh tick (combinational from the count)
// ---------------------------------------------------------------------------
module rgbw_frame_timer #(
  parameter int FRAME_PERIOD = 1600000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CNT_W = $clog2(FRAME_PERIOD);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_PERIOD - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_tc;

  assign w_tc   = (r_count == '0);
  assign o_tick = i_enable && w_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RELOAD;
    end else if (!i_enable || w_tc) begin
      r_count <= RELOAD;
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/rgbw_frame_sched.sv
// ---------------------------------------------------------------------------
// rgbw_frame_sched
// Frame scheduler for the RGBW serial-output path. Each frame reads NUM_LEDS
// pixels from a 1-cycle-latency frame memory, pushes one FIFO word per pixel
// and then one stream-reset word. Frames are started by the refresh timer or
// by a host request; requests arriving while a frame is pending or running
// merge into a single pending frame.
// Ports:
//   clk               in   system clock (same as FIFO write clock)
//   rst               in   async active-low reset; release is synchronized
//   in_enable         in   periodic refresh enable
//   in_frame_req      in   1-clk host frame request
//   in_mem_rdata      in   pixel {G,R,B}, valid 1 clk after out_mem_rd
//   in_wr_fifo_full   in   FIFO full flag
//   out_mem_rd        out  1-clk memory read strobe
//   out_mem_addr      out  pixel address
//   out_wr_fifo_en    out  1-clk FIFO write enable
//   out_wr_fifo_data  out  FIFO word (see rgbw_pkg)
//   out_busy          out  frame in progress
//   out_frame_done    out  1-clk pulse after the stream-reset word is written
//   out_frame_count   out  completed frames, wrapping 16-bit
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for pending; on start clear pending, addr=0, busy=1
// ST_FETCH    | read strobe is high for the current address
// ST_MEM_WAIT | memory data valid; capture it as a pixel word
// ST_PUSH     | write pixel word when not full, then next pixel or reset word
// ST_RST_WORD | load stream-reset word, then write it when not full
// ST_DONE     | reset word being written; pulse done, bump count, drop busy
// ---------------------------------------------------------------------------
module rgbw_frame_sched
  import rgbw_pkg::*;
#(
  parameter  int NUM_LEDS     = 64,
  parameter  int FRAME_PERIOD = 1600000,
  localparam int ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_enable,
  input  logic              in_frame_req,
  input  logic [23:0]       in_mem_rdata,
  input  logic              in_wr_fifo_full,
  output logic              out_mem_rd,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_wr_fifo_en,
  output logic [31:0]       out_wr_fifo_data,
  output logic              out_busy,
  output logic              out_frame_done,
  output logic [15:0]       out_frame_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);

  // Reset: asserts asynchronously, releases two clocks later on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  logic w_tick;

  rgbw_frame_timer #(
    .FRAME_PERIOD (FRAME_PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (w_rst_n),
    .i_enable (in_enable),
    .o_tick   (w_tick)
  );

  frame_state_t      r_state;
  logic              r_pending;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mem_rd;
  logic              r_fifo_en;
  logic [31:0]       r_data;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_count;

  frame_state_t      w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_mem_rd_nxt;
  logic              w_fifo_en_nxt;
  logic [31:0]       w_data_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [15:0]       w_count_nxt;
  logic              w_start;

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_mem_rd_nxt  = 1'b0;
    w_fifo_en_nxt = 1'b0;
    w_data_nxt    = r_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_count_nxt   = r_count;
    w_start       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (r_pending) begin
          w_start      = 1'b1;
          w_addr_nxt   = '0;
          w_busy_nxt   = 1'b1;
          w_mem_rd_nxt = 1'b1;
          w_state_nxt  = ST_FETCH;
        end
      end

      ST_FETCH: begin
        w_state_nxt = ST_MEM_WAIT;
      end

      ST_MEM_WAIT: begin
        w_data_nxt  = pixel_word(in_mem_rdata);
        w_state_nxt = ST_PUSH;
      end

      ST_PUSH: begin
        // The write enable is registered: full is sampled here and the word
        // appears on the FIFO port one clock later, with r_data still stable.
        if (!in_wr_fifo_full) begin
          w_fifo_en_nxt = 1'b1;
          if (r_addr == LAST_ADDR) begin
            w_state_nxt = ST_RST_WORD;
          end else begin
            w_addr_nxt   = r_addr + 1'b1;
            w_mem_rd_nxt = 1'b1;
            w_state_nxt  = ST_FETCH;
          end
        end
      end

      ST_RST_WORD: begin
        // First cycle here the last pixel word is still on the FIFO port, so
        // the reset word is only loaded at its end; the stream_reset bit of
        // r_data tells the two cycles apart.
        if (!r_data[BNUM_STREAM_RESET]) begin
          w_data_nxt = STREAM_RST_WORD;
        end else if (!in_wr_fifo_full) begin
          w_fifo_en_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end
      end

      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_count_nxt = r_count + 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_addr    <= '0;
      r_mem_rd  <= 1'b0;
      r_fifo_en <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      // New requests win over the clear, so a request landing on the start
      // cycle is not lost; everything else merges into the one pending flag.
      r_pending <= (r_pending && !w_start) || w_tick || in_frame_req;
      r_addr    <= w_addr_nxt;
      r_mem_rd  <= w_mem_rd_nxt;
      r_fifo_en <= w_fifo_en_nxt;
      r_data    <= w_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign out_mem_rd       = r_mem_rd;
  assign out_mem_addr     = r_addr;
  assign out_wr_fifo_en   = r_fifo_en;
  assign out_wr_fifo_data = r_data;
  assign out_busy         = r_busy;
  assign out_frame_done   = r_done;
  assign out_frame_count  = r_count;

endmodule

// File: tb/tb_rgbw_frame_sched.sv
module tb_rgbw_frame_sched;

  localparam int NL = 4;
  localparam int FP = 100;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_enable = 1'b0;
  logic          in_frame_req = 1'b0;
  logic [23:0]   in_mem_rdata = 24'h0;
  logic          in_wr_fifo_full = 1'b0;
  logic          out_mem_rd;
  logic [AW-1:0] out_mem_addr;
  logic          out_wr_fifo_en;
  logic [31:0]   out_wr_fifo_data;
  logic          out_busy;
  logic          out_frame_done;
  logic [15:0]   out_frame_count;

  rgbw_frame_sched #(
    .NUM_LEDS     (NL),
    .FRAME_PERIOD (FP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_enable        (in_enable),
    .in_frame_req     (in_frame_req),
    .in_mem_rdata     (in_mem_rdata),
    .in_wr_fifo_full  (in_wr_fifo_full),
    .out_mem_rd       (out_mem_rd),
    .out_mem_addr     (out_mem_addr),
    .out_wr_fifo_en   (out_wr_fifo_en),
    .out_wr_fifo_data (out_wr_fifo_data),
    .out_busy         (out_busy),
    .out_frame_done   (out_frame_done),
    .out_frame_count  (out_frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [23:0] mem [NL];
  logic [31:0] exp_w [5];

  // Frame memory: data valid only in the clock after the read strobe.
  always @(posedge clk) begin
    if (out_mem_rd) in_mem_rdata <= mem[out_mem_addr];
    else            in_mem_rdata <= 24'h5A5A5A;
  end

  logic [31:0] wq [$];
  int          starts [$];
  int          cyc = 0;
  int          last_en = -10;
  int          spacing_err = 0;
  int          done_cnt = 0;
  int          done_err = 0;
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;
  logic        prev_rst_wr = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (out_wr_fifo_en) begin
      wq.push_back(out_wr_fifo_data);
      if (cyc - last_en < 2) spacing_err++;
      last_en = cyc;
    end
    if (out_frame_done) begin
      done_cnt++;
      if (!prev_rst_wr || prev_done) done_err++;
    end
    if (out_busy && !prev_busy) starts.push_back(cyc);
    prev_busy   = out_busy;
    prev_done   = out_frame_done;
    prev_rst_wr = out_wr_fifo_en && (out_wr_fifo_data == 32'hC000_0000);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk) in_frame_req = 1'b1;
    @(negedge clk) in_frame_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_wait"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_rd(input int addr, input int limit, input string tag);
    int n = 0;
    while (!(out_mem_rd && out_mem_addr == AW'(addr)) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rd_wait"}, 32'(out_mem_rd && out_mem_addr == AW'(addr)), 32'd1);
  endtask

  task automatic check_frame(input int base, input string tag);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_w%0d", tag, i), (base + i < wq.size()) ? wq[base + i] : 32'hFFFF_FFFF, exp_w[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w0;
    int s0;
    int d0;
    int en_cnt;

    mem[0] = 24'h112233;
    mem[1] = 24'h445566;
    mem[2] = 24'h778899;
    mem[3] = 24'hAABBCC;
    exp_w[0] = 32'h8011_2233;
    exp_w[1] = 32'h8044_5566;
    exp_w[2] = 32'h8077_8899;
    exp_w[3] = 32'h80AA_BBCC;
    exp_w[4] = 32'hC000_0000;

    // Reset state
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(out_busy),         32'd0);
    check("rst_fifo_en", 32'(out_wr_fifo_en),  32'd0);
    check("rst_mem_rd", 32'(out_mem_rd),       32'd0);
    check("rst_addr",   32'(out_mem_addr),     32'd0);
    check("rst_data",   out_wr_fifo_data,      32'd0);
    check("rst_count",  32'(out_frame_count),  32'd0);
    check("rst_done",   32'(out_frame_done),   32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single requested frame: latency and contents
    w0 = wq.size();
    pulse_req();
    lat = 0;
    while (!out_wr_fifo_en && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("req_latency", 32'(lat), 32'd4);
    wait_done(1, 60, "req1");
    check("req1_nwords", 32'(wq.size() - w0), 32'd5);
    check_frame(w0, "req1");
    check("req1_count", 32'(out_frame_count), 32'd1);
    check("req1_busy_after", 32'(out_busy), 32'd0);

    // Periodic refresh: three frames, 100 clocks apart
    w0 = wq.size();
    s0 = starts.size();
    d0 = done_cnt;
    @(negedge clk) in_enable = 1'b1;
    wait_done(d0 + 3, 500, "periodic");
    check("periodic_starts", 32'(starts.size() - s0), 32'd3);
    check("periodic_gap1", 32'(starts[s0 + 1] - starts[s0]), 32'd100);
    check("periodic_gap2", 32'(starts[s0 + 2] - starts[s0 + 1]), 32'd100);
    check_frame(w0 + 10, "periodic_f3");
    check("periodic_count", 32'(out_frame_count), 32'd4);

    // Enable dropped at pixel 2: frame finishes, no more ticks
    wait_rd(2, 150, "endrop");
    in_enable = 1'b0;
    wait_done(d0 + 4, 60, "endrop");
    check("endrop_nwords", 32'(wq.size() - w0), 32'd20);
    check_frame(w0 + 15, "endrop_f4");
    repeat (250) @(negedge clk);
    check("endrop_no_tick", 32'(starts.size() - s0), 32'd4);
    check("endrop_count", 32'(out_frame_count), 32'd5);

    // Requests while busy merge into exactly one follow-on frame
    w0 = wq.size();
    s0 = starts.size();
    d0 = done_cnt;
    pulse_req();
    lat = 0;
    while (!out_busy && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("busyreq_busy", 32'(out_busy), 32'd1);
    repeat (2) @(negedge clk);
    pulse_req();
    repeat (2) @(negedge clk);
    pulse_req();
    wait_done(d0 + 2, 120, "busyreq");
    repeat (50) @(negedge clk);
    check("busyreq_frames", 32'(starts.size() - s0), 32'd2);
    check("busyreq_nwords", 32'(wq.size() - w0), 32'd10);
    check_frame(w0 + 5, "busyreq_f2");
    check("busyreq_count", 32'(out_frame_count), 32'd7);

    // Tick and request in the same clock -> one frame
    w0 = wq.size();
    s0 = starts.size();
    d0 = done_cnt;
    @(negedge clk) in_enable = 1'b1;
    repeat (99) @(negedge clk);
    in_frame_req = 1'b1;
    @(negedge clk) in_frame_req = 1'b0;
    wait_done(d0 + 1, 60, "tickreq");
    in_enable = 1'b0;
    repeat (30) @(negedge clk);
    check("tickreq_frames", 32'(starts.size() - s0), 32'd1);
    check("tickreq_nwords", 32'(wq.size() - w0), 32'd5);
    check("tickreq_count", 32'(out_frame_count), 32'd8);

    // FIFO full held for 20 clocks in PUSH
    w0 = wq.size();
    d0 = done_cnt;
    pulse_req();
    wait_rd(1, 20, "full");
    in_wr_fifo_full = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_wr_fifo_en) en_cnt++;
    end
    in_wr_fifo_full = 1'b0;
    wait_done(d0 + 1, 60, "full");
    check("full_no_write", 32'(en_cnt), 32'd0);
    check("full_nwords", 32'(wq.size() - w0), 32'd5);
    check_frame(w0, "full");
    check("full_count", 32'(out_frame_count), 32'd9);

    // Reset mid-frame at pixel 2
    pulse_req();
    wait_rd(2, 20, "midrst");
    #2 rst = 1'b0;
    #1;
    check("midrst_busy",   32'(out_busy),        32'd0);
    check("midrst_mem_rd", 32'(out_mem_rd),      32'd0);
    check("midrst_addr",   32'(out_mem_addr),    32'd0);
    check("midrst_fifo_en", 32'(out_wr_fifo_en), 32'd0);
    check("midrst_data",   out_wr_fifo_data,     32'd0);
    check("midrst_count",  32'(out_frame_count), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    w0 = wq.size();
    d0 = done_cnt;
    check("post_rst_busy", 32'(out_busy), 32'd0);
    pulse_req();
    wait_rd(0, 10, "post_rst");
    check("post_rst_count0", 32'(out_frame_count), 32'd0);
    wait_done(d0 + 1, 60, "post_rst");
    check("post_rst_nwords", 32'(wq.size() - w0), 32'd5);
    check_frame(w0, "post_rst");
    check("post_rst_count1", 32'(out_frame_count), 32'd1);

    check("write_spacing", 32'(spacing_err), 32'd0);
    check("done_alignment", 32'(done_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
